// File: rtl/gpio_cmd_pkg.sv
// -----------------------------------------------------------------------------
// gpio_cmd_pkg
//   Shared definitions for the GPIO command front-end:
//     - edge_mode_e : per-channel edge selection (off / rise / fall / both)
//     - deb_cnt_width(): width of the per-channel debounce counter
// -----------------------------------------------------------------------------
package gpio_cmd_pkg;

  // Bit 0 enables rising-edge detection and bit 1 enables falling-edge
  // detection, so EDGE_BOTH is simply both bits set.
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // The counter must be able to hold DEB_CYCLES. The function is clamped to
  // a width of at least 1 so that a degenerate parameter still elaborates.
  function automatic int deb_cnt_width(input int deb_cycles);
    return (deb_cycles < 1) ? 1 : $clog2(deb_cycles + 1);
  endfunction

endpackage : gpio_cmd_pkg

// File: rtl/gpio_cmd_channel.sv
// -----------------------------------------------------------------------------
// gpio_cmd_channel
//   One GPIO command channel. It synchronises the pad, optionally debounces it,
//   and detects the selected edge. Each detected edge produces a one-cycle
//   pulse and sets a sticky pending flag, which is cleared by ack.
//
//   Optional feature: define GPIO_DEBOUNCE_EN to insert the debounce filter.
//   With the macro undefined, the filtered level is the synchroniser output
//   and DEB_CYCLES is ignored.
//
//   Ports
//     clk      in  system clock
//     rstb     in  synchronous reset, active-low
//     en       in  enable; when low, the channel holds its state and forces the pulse low
//     pad      in  asynchronous pad input
//     mode     in  edge select, bit0 = rise, bit1 = fall
//     ack      in  clears pending (an edge in the same cycle takes priority)
//     level    out synchronised / filtered level
//     pulse    out one-cycle registered pulse per detected edge
//     pending  out sticky flag: edge seen, not yet acked
// -----------------------------------------------------------------------------
module gpio_cmd_channel
  import gpio_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       en,
  input  logic       pad,
  input  logic [1:0] mode,
  input  logic       ack,
  output logic       level,
  output logic       pulse,
  output logic       pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   filt;
  logic                   prev_q;
  logic                   rise;
  logic                   fall;
  logic                   evt;

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int              CNT_W    = deb_cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // The filtered level follows the synchroniser only after the new value
  // has been seen for DEB_CYCLES consecutive cycles. Any return to the old
  // value restarts the count, so shorter glitches are suppressed.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (en) begin
      if (sync_out != filt_q) begin
        if (cnt_q == DEB_LAST) begin
          filt_q <= sync_out;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_out;
`endif

  // The mode only gates the comparison of the current level with the
  // previous level, so changing the mode by itself can never create an edge.
  assign rise = filt & ~prev_q;
  assign fall = ~filt & prev_q;
  assign evt  = (mode[0] & rise) | (mode[1] & fall);

  // NOTE: reset is sampled on the clock edge only (no async path), and every
  // register here uses <= so all flops see pre-edge values, which is what
  // makes the synchroniser chain shift by exactly one stage per clock.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse   <= 1'b0;
      pending <= 1'b0;
    end else if (en) begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad};
      prev_q  <= filt;
      pulse   <= evt;
      // When an edge and an ack arrive in the same cycle, the set takes priority.
      pending <= evt | (pending & ~ack);
    end else begin
      // While disabled, state is frozen, but the pulse must not stay high.
      pulse <= 1'b0;
    end
  end

  assign level = filt;

endmodule : gpio_cmd_channel

// File: rtl/gpio_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_cmd_ctrl
//   N-channel GPIO command front-end placed between the input pads and the
//   RSA control FSM. Each channel is an independent gpio_cmd_channel.
//
//   Optional feature: define GPIO_DEBOUNCE_EN to add a DEB_CYCLES debounce
//   filter per channel. This adds DEB_CYCLES cycles of latency.
//
//   Ports
//     clk          in  system clock
//     rstb         in  synchronous reset, active-low
//     en           in  global enable; low freezes all state
//     gpio_in      in  [N_CH]     asynchronous pad inputs
//     edge_mode    in  [2*N_CH]   per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//     cmd_ack      in  [N_CH]     per-channel clear of cmd_pending
//     gpio_level   out [N_CH]     synchronised (and filtered) level
//     cmd_pulse    out [N_CH]     one-cycle pulse per detected edge
//     cmd_pending  out [N_CH]     sticky flag: edge seen, not yet acked
// -----------------------------------------------------------------------------
module gpio_cmd_ctrl
  import gpio_cmd_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                en,
  input  logic [N_CH-1:0]     gpio_in,
  input  logic [2*N_CH-1:0]   edge_mode,
  input  logic [N_CH-1:0]     cmd_ack,
  output logic [N_CH-1:0]     gpio_level,
  output logic [N_CH-1:0]     cmd_pulse,
  output logic [N_CH-1:0]     cmd_pending
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    gpio_cmd_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_channel (
      .clk     (clk),
      .rstb    (rstb),
      .en      (en),
      .pad     (gpio_in[i]),
      .mode    (edge_mode[2*i +: 2]),
      .ack     (cmd_ack[i]),
      .level   (gpio_level[i]),
      .pulse   (cmd_pulse[i]),
      .pending (cmd_pending[i])
    );
  end

endmodule : gpio_cmd_ctrl

// File: tb/tb_gpio_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_cmd_ctrl
//   Bench for gpio_cmd_ctrl (N_CH=2, SYNC_STAGES=2, DEB_CYCLES=4). Each
//   stimulus that should produce an edge pushes {cycle, channel} into a
//   scoreboard queue. A negedge monitor checks cmd_pulse on every cycle
//   against that queue, so pulses that are missing, late, extra, or too long
//   are all reported. Pending, level, and reset behaviour are checked inline
//   by each scenario task.
// -----------------------------------------------------------------------------
module tb_gpio_cmd_ctrl;
  import gpio_cmd_pkg::*;

  localparam int N_CH        = 2;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYCLES  = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SYNC_STAGES + 1 + DEB_CYCLES;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  logic                clk = 1'b0;
  logic                rstb;
  logic                en;
  logic [N_CH-1:0]     gpio_in;
  logic [2*N_CH-1:0]   edge_mode;
  logic [N_CH-1:0]     cmd_ack;
  logic [N_CH-1:0]     gpio_level;
  logic [N_CH-1:0]     cmd_pulse;
  logic [N_CH-1:0]     cmd_pending;

  gpio_cmd_ctrl #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .en          (en),
    .gpio_in     (gpio_in),
    .edge_mode   (edge_mode),
    .cmd_ack     (cmd_ack),
    .gpio_level  (gpio_level),
    .cmd_pulse   (cmd_pulse),
    .cmd_pending (cmd_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int ch;
  } exp_pulse_t;

  exp_pulse_t sb[$];
  int         cyc         = 0;
  int         vectors     = 0;
  int         miscompares = 0;
  bit         mon_on      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor. At the negedge after posedge n, cyc equals n.
  always @(negedge clk) begin
    logic exp_p;
    if (mon_on) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        exp_p = 1'b0;
        for (int k = 0; k < sb.size(); k++) begin
          if (sb[k].cyc == cyc && sb[k].ch == ch) begin
            exp_p = 1'b1;
            sb.delete(k);
            break;
          end
        end
        vectors++;
        if (cmd_pulse[ch] !== exp_p) begin
          miscompares++;
          $display("FAIL pulse_ch%0d cyc=%0d got=%b exp=%b", ch, cyc, cmd_pulse[ch], exp_p);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int ch);
    exp_pulse_t e;
    e.cyc = cyc + LAT;
    e.ch  = ch;
    sb.push_back(e);
  endtask

  task automatic set_mode(input int ch, input edge_mode_e m);
    edge_mode[2*ch +: 2] = m;
  endtask

  task automatic test_reset();
    rstb = 1'b0; en = 1'b1; gpio_in = '0; edge_mode = '0; cmd_ack = '0;
    tick(3);
    vectors++;
    if (gpio_level !== 2'b00) begin miscompares++; $display("FAIL reset_level got=%b exp=00", gpio_level); end
    vectors++;
    if (cmd_pulse !== 2'b00) begin miscompares++; $display("FAIL reset_pulse got=%b exp=00", cmd_pulse); end
    vectors++;
    if (cmd_pending !== 2'b00) begin miscompares++; $display("FAIL reset_pending got=%b exp=00", cmd_pending); end
    rstb   = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_single_rise();
    set_mode(0, EDGE_RISE);
    set_mode(1, EDGE_RISE);
    gpio_in[0] = 1'b1;
    expect_pulse(0);
    tick(LAT - 1);
    vectors++;
    if (cmd_pending !== 2'b00) begin miscompares++; $display("FAIL rise_early_pending got=%b exp=00", cmd_pending); end
    tick(1);
    vectors++;
    if (cmd_pending !== 2'b01) begin miscompares++; $display("FAIL rise_pending got=%b exp=01", cmd_pending); end
    vectors++;
    if (gpio_level !== 2'b01) begin miscompares++; $display("FAIL rise_level got=%b exp=01", gpio_level); end
    cmd_ack = 2'b01;
    tick(1);
    cmd_ack = 2'b00;
    vectors++;
    if (cmd_pending !== 2'b00) begin miscompares++; $display("FAIL rise_ack got=%b exp=00", cmd_pending); end
  endtask

  task automatic test_both_edges();
    // A falling edge with only rise enabled must not produce a pulse.
    gpio_in[0] = 1'b0;
    tick(LAT + 2);
    vectors++;
    if (cmd_pending[0] !== 1'b0) begin miscompares++; $display("FAIL fall_in_rise_mode got=%b exp=0", cmd_pending[0]); end
    set_mode(0, EDGE_BOTH);
    tick(2);
    gpio_in[0] = 1'b1;
    expect_pulse(0);
    tick(LAT);
    vectors++;
    if (cmd_pending[0] !== 1'b1) begin miscompares++; $display("FAIL both_first_pending got=%b exp=1", cmd_pending[0]); end
    cmd_ack[0] = 1'b1;
    tick(1);
    cmd_ack[0] = 1'b0;
    vectors++;
    if (cmd_pending[0] !== 1'b0) begin miscompares++; $display("FAIL both_ack got=%b exp=0", cmd_pending[0]); end
    tick(10 - LAT - 1);
    gpio_in[0] = 1'b0;
    expect_pulse(0);
    tick(LAT);
    vectors++;
    if (cmd_pending[0] !== 1'b1) begin miscompares++; $display("FAIL both_second_pending got=%b exp=1", cmd_pending[0]); end
    cmd_ack[0] = 1'b1;
    tick(1);
    cmd_ack[0] = 1'b0;
  endtask

  task automatic test_ack_collision();
    gpio_in[0] = 1'b1;
    expect_pulse(0);
    cmd_ack[1] = 1'b1;           // ack on an idle channel is a no-op
    tick(LAT - 1);
    cmd_ack[0] = 1'b1;           // lands on the same edge as the event
    tick(1);
    vectors++;
    if (cmd_pending !== 2'b01) begin miscompares++; $display("FAIL collide_set_wins got=%b exp=01", cmd_pending); end
    tick(1);
    vectors++;
    if (cmd_pending !== 2'b00) begin miscompares++; $display("FAIL collide_late_ack got=%b exp=00", cmd_pending); end
    cmd_ack = 2'b00;
  endtask

  task automatic test_en_freeze();
    gpio_in[1] = 1'b1;
    expect_pulse(1);
    tick(LAT);
    vectors++;
    if (cmd_pending !== 2'b10) begin miscompares++; $display("FAIL freeze_pre_pending got=%b exp=10", cmd_pending); end
    en         = 1'b0;
    gpio_in[0] = 1'b0;
    cmd_ack[1] = 1'b1;           // must be ignored while disabled
    tick(6);
    vectors++;
    if (cmd_pending !== 2'b10) begin miscompares++; $display("FAIL freeze_pending_held got=%b exp=10", cmd_pending); end
    vectors++;
    if (gpio_level !== 2'b11) begin miscompares++; $display("FAIL freeze_level_held got=%b exp=11", gpio_level); end
    cmd_ack = 2'b00;
    en      = 1'b1;
    expect_pulse(0);
    tick(LAT);
    vectors++;
    if (cmd_pending !== 2'b11) begin miscompares++; $display("FAIL freeze_resume_pending got=%b exp=11", cmd_pending); end
    vectors++;
    if (gpio_level !== 2'b10) begin miscompares++; $display("FAIL freeze_resume_level got=%b exp=10", gpio_level); end
  endtask

  task automatic test_reset_mid();
    set_mode(1, EDGE_BOTH);
    gpio_in[1] = 1'b0;
    expect_pulse(1);
    tick(LAT);
    rstb = 1'b0;
    #1;
    vectors++;
    if (cmd_pulse !== 2'b10 || cmd_pending !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_no_clock pulse=%b pending=%b exp pulse=10 pending=11", cmd_pulse, cmd_pending);
    end
    rstb = 1'b1;
    #1;
    rstb = 1'b0;
    #1;
    vectors++;
    if (cmd_pending !== 2'b11) begin miscompares++; $display("FAIL reset_toggle_no_clock got=%b exp=11", cmd_pending); end
    gpio_in = 2'b11;
    set_mode(0, EDGE_BOTH);
    tick(1);
    vectors++;
    if (cmd_pulse !== 2'b00 || cmd_pending !== 2'b00 || gpio_level !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_sync pulse=%b pending=%b level=%b exp all 00", cmd_pulse, cmd_pending, gpio_level);
    end
    tick(2);
    rstb = 1'b1;
    // Pads high through reset release: both channels see a simultaneous rise.
    expect_pulse(0);
    expect_pulse(1);
    tick(LAT);
    vectors++;
    if (cmd_pending !== 2'b11) begin miscompares++; $display("FAIL release_pending got=%b exp=11", cmd_pending); end
    vectors++;
    if (gpio_level !== 2'b11) begin miscompares++; $display("FAIL release_level got=%b exp=11", gpio_level); end
  endtask

  task automatic test_mode_off();
    cmd_ack = 2'b11;
    tick(1);
    cmd_ack = 2'b00;
    set_mode(0, EDGE_OFF);
    gpio_in[0] = 1'b0;
    tick(LAT + 2);
    vectors++;
    if (gpio_level[0] !== 1'b0) begin miscompares++; $display("FAIL off_level got=%b exp=0", gpio_level[0]); end
    vectors++;
    if (cmd_pending !== 2'b00) begin miscompares++; $display("FAIL off_pending got=%b exp=00", cmd_pending); end
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce();
    set_mode(0, EDGE_RISE);
    gpio_in[0] = 1'b1;
    tick(2);
    gpio_in[0] = 1'b0;
    tick(12);
    vectors++;
    if (cmd_pending[0] !== 1'b0 || gpio_level[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL deb_glitch pending=%b level=%b exp 0 0", cmd_pending[0], gpio_level[0]);
    end
    gpio_in[0] = 1'b1;
    expect_pulse(0);
    tick(LAT);
    vectors++;
    if (cmd_pending[0] !== 1'b1 || gpio_level[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL deb_stable pending=%b level=%b exp 1 1", cmd_pending[0], gpio_level[0]);
    end
  endtask
`else
  task automatic test_short_pulse();
    // Without the filter, a 2-cycle high pulse is a real rise. The following
    // fall is ignored in rise mode.
    set_mode(0, EDGE_RISE);
    gpio_in[0] = 1'b1;
    expect_pulse(0);
    tick(2);
    gpio_in[0] = 1'b0;
    tick(LAT + 2);
    vectors++;
    if (cmd_pending[0] !== 1'b1 || gpio_level[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL short_pulse pending=%b level=%b exp 1 0", cmd_pending[0], gpio_level[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_rise();
    test_both_edges();
    test_ack_collision();
    test_en_freeze();
    test_reset_mid();
    test_mode_off();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`else
    test_short_pulse();
`endif
    tick(4);
    mon_on = 1'b0;
    while (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_missing ch%0d expected at cyc=%0d got=none", sb[0].ch, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_gpio_cmd_ctrl
